mem_copy_sequencer: RTL and testbench
=====================================

MEM_COPY_SEQUENCER -- requirements
Module: mem_copy_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, meaning SRAM word width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clock and reset_n.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  copy request, level; a copy launches on its 0->1 transition.
REQ-007 Port: src_base  input  ADDR_W  first source word address.
REQ-008 Port: dst_base  input  ADDR_W  first destination word address.
REQ-009 Port: length  input  ADDR_W  number of words to copy.
REQ-010 Port: Src_ReadAddress1  output  ADDR_W  source sram_2R1W read address.
REQ-011 Port: Src_ReadBus1  input  DATA_W  source read data, valid one cycle after its address.
REQ-012 Port: Dst_WriteAddress  output  ADDR_W  destination write address.
REQ-013 Port: Dst_WriteBus  output  DATA_W  destination write data.
REQ-014 Port: Dst_WriteEnable  output  1  destination write strobe.
REQ-015 Port: busy  output  1  high while a copy is in progress.
REQ-016 Port: done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-018 start SHALL be registered each cycle, and a launch SHALL occur only at an edge E0 where start=1 and the registered previous start=0.
REQ-019 A launch SHALL be accepted only in IDLE; start edges in RUN, DRAIN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 At launch, src_base, dst_base and length SHALL be latched; later input changes SHALL NOT affect the copy in progress.
REQ-021 At launch with length=0, the FSM SHALL go IDLE->DONE with no write issued.
REQ-022 At launch with length>0, the FSM SHALL go IDLE->RUN with the read counter i=0.
REQ-023 In RUN, Src_ReadAddress1 SHALL equal src+i (registered), and i SHALL increment each cycle.
REQ-024 The FSM SHALL go RUN->DRAIN after read address src+length-1 has been driven.
REQ-025 Dst_WriteEnable SHALL be a register asserted exactly one cycle after each read address is driven, with Dst_WriteAddress=dst+j for the j-th word.
REQ-026 Dst_WriteBus SHALL be combinationally equal to Src_ReadBus1.
REQ-027 DRAIN SHALL last one cycle to issue the final write, then the FSM SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-029 Timing: write j SHALL occur in the cycle following edge E0+1+j, and done SHALL be high in the cycle following edge E0+length+1.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_W (src+i and dst+j wrap, for example FFFF->0000).
REQ-031 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-032 Dst_WriteEnable SHALL be asserted for exactly length cycles per copy, contiguously.
REQ-033 When Dst_WriteEnable=0, Dst_WriteAddress SHALL be held at its last value.

Reset
REQ-034 When reset_n=0, the block SHALL asynchronously force FSM=IDLE, i=0, Dst_WriteEnable=0, done=0, busy=0, Src_ReadAddress1=0, Dst_WriteAddress=0, and previous-start register=0.
REQ-035 A reset during RUN or DRAIN SHALL abort the copy, with Dst_WriteEnable=0 immediately and no further writes.
REQ-036 After reset release with start already held high, a launch SHALL occur (the previous-start register is 0 after reset).

Verification
REQ-037 Scenario: src=0010, dst=0200, length=4, start rises -> writes to 0200..0203 with data mem_src[0010..0013] on 4 consecutive cycles; done pulses 5 cycles after E0; busy high over 6 cycles.
REQ-038 Scenario: length=0 -> no Dst_WriteEnable; done pulses in the cycle after E0; busy high 1 cycle.
REQ-039 Scenario: src=FFFE, dst=FFFF, length=3 -> reads FFFE, FFFF, 0000; writes FFFF, 0000, 0001.
REQ-040 Scenario: start held high through and after completion -> exactly one copy occurs; a second copy launches only after start goes 0 then 1.
REQ-041 Scenario: reset_n pulsed low after the 2nd write of a length=8 copy -> Dst_WriteEnable drops immediately, no done pulse occurs, and the block is IDLE after release.
REQ-042 Scenario: a start edge during RUN with altered src/dst/length -> the original copy completes unchanged and the second start is dropped.

Source files
------------

// File: rtl/mem_copy_sequencer.sv
// Purpose : copies a block of words from a source SRAM read port to a destination write port.
// Latency : write j lands in the cycle after edge E0+1+j; done pulses one cycle after the last write.
// Backpress: none; one word per cycle, start edges seen while busy are dropped, not queued.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   start                   level request; a copy launches on its 0->1 transition while idle
//   src_base/dst_base       first source / destination word address (latched at launch)
//   length                  number of words to copy (latched at launch, 0 allowed)
//   Src_ReadAddress1        registered source read address (data returns one cycle later)
//   Src_ReadBus1            source read data
//   Dst_WriteAddress/Bus/Enable  destination write port; address holds when not writing
//   busy, done              busy while a copy is active; one-cycle completion pulse
module mem_copy_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] Src_ReadAddress1,
  input  logic [DATA_W-1:0] Src_ReadBus1,
  output logic [ADDR_W-1:0] Dst_WriteAddress,
  output logic [DATA_W-1:0] Dst_WriteBus,
  output logic              Dst_WriteEnable,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              startPrev;
  logic              launch;
  logic [ADDR_W-1:0] srcLat;
  logic [ADDR_W-1:0] dstLat;
  logic [ADDR_W-1:0] lenLat;
  logic [ADDR_W-1:0] readIdx;

  assign launch = start & ~startPrev;

  // Read data arrives one cycle after its address, exactly when the matching
  // write is strobed, so the write bus is a straight pass-through.
  assign Dst_WriteBus = Src_ReadBus1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      startPrev        <= 1'b0;
      srcLat           <= '0;
      dstLat           <= '0;
      lenLat           <= '0;
      readIdx          <= '0;
      Src_ReadAddress1 <= '0;
      Dst_WriteAddress <= '0;
      Dst_WriteEnable  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      startPrev       <= start;
      Dst_WriteEnable <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            srcLat  <= src_base;
            dstLat  <= dst_base;
            lenLat  <= length;
            readIdx <= '0;
            busy    <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state            <= RUN;
              // First read address goes out straight from the inputs so word 0
              // is requested in the very first RUN cycle.
              Src_ReadAddress1 <= src_base;
            end
          end
        end
        RUN: begin
          // The word addressed this cycle is written next cycle.
          Dst_WriteEnable  <= 1'b1;
          Dst_WriteAddress <= dstLat + readIdx;
          if (readIdx == lenLat - ONE) begin
            state <= DRAIN;
          end else begin
            readIdx          <= readIdx + ONE;
            Src_ReadAddress1 <= srcLat + readIdx + ONE;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_sequencer.sv
// Purpose : self-checking bench for mem_copy_sequencer against a timing/address model.
// Latency : n/a (bench).
// Backpress: n/a (bench).
module tb_mem_copy_sequencer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  src_base = '0;
  logic [15:0]  dst_base = '0;
  logic [15:0]  length = '0;
  logic [15:0]  Src_ReadAddress1;
  logic [127:0] Src_ReadBus1 = '0;
  logic [15:0]  Dst_WriteAddress;
  logic [127:0] Dst_WriteBus;
  logic         Dst_WriteEnable;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  // Observation record, indexed by cycle k = cycle following edge E0+k.
  logic [15:0]  wrAddrQ[$];
  logic [127:0] wrDataQ[$];
  int           wrCycQ[$];
  int           doneCycQ[$];
  logic [15:0]  rdAddrQ[$];
  int           busyCnt;
  int           holdErr;
  bit           haveWr;
  logic [15:0]  lastWrAddr;
  logic [15:0]  altSrc, altDst, altLen;

  mem_copy_sequencer #(.ADDR_W(16), .DATA_W(128)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .Src_ReadAddress1(Src_ReadAddress1), .Src_ReadBus1(Src_ReadBus1),
    .Dst_WriteAddress(Dst_WriteAddress), .Dst_WriteBus(Dst_WriteBus),
    .Dst_WriteEnable(Dst_WriteEnable), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Source SRAM content is a fixed function of the address; low 32 bits make it unique.
  function automatic logic [127:0] memWord(input logic [15:0] a);
    logic [31:0] h;
    h = {16'h0, a} * 32'h9E3779B1;
    return {h, ~h, h ^ 32'hA5A5A5A5, a, a};
  endfunction

  // Synchronous read port: data valid one cycle after its address.
  always @(posedge clock) Src_ReadBus1 <= memWord(Src_ReadAddress1);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic clearObs();
    wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
    doneCycQ.delete(); rdAddrQ.delete();
    busyCnt = 0; holdErr = 0; haveWr = 0;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clock);
    start = 1'b0; src_base = s; dst_base = d; length = l;
    @(negedge clock);
    start = 1'b1;
  endtask

  // Samples n cycles starting with the cycle right after the launching edge.
  // toggleAt >= 0 drops start in that cycle and re-raises it next cycle with alt inputs.
  task automatic observe(input int n, input int toggleAt);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      rdAddrQ.push_back(Src_ReadAddress1);
      if (Dst_WriteEnable === 1'b1) begin
        wrAddrQ.push_back(Dst_WriteAddress);
        wrDataQ.push_back(Dst_WriteBus);
        wrCycQ.push_back(k);
        lastWrAddr = Dst_WriteAddress;
        haveWr = 1;
      end else if (haveWr && Dst_WriteAddress !== lastWrAddr) begin
        holdErr++;
      end
      if (done === 1'b1) doneCycQ.push_back(k);
      if (busy === 1'b1) busyCnt++;
      if (k == toggleAt) start = 1'b0;
      if (toggleAt >= 0 && k == toggleAt + 1) begin
        start = 1'b1; src_base = altSrc; dst_base = altDst; length = altLen;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (Src_ReadAddress1 !== 16'h0) begin failures++; $display("FAIL reset_rdaddr got=%h exp=0000", Src_ReadAddress1); end
    checks++; if (Dst_WriteAddress !== 16'h0) begin failures++; $display("FAIL reset_wraddr got=%h exp=0000", Dst_WriteAddress); end
    checks++; if (Dst_WriteEnable !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", Dst_WriteEnable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [15:0] s = 16'h0010, d = 16'h0200, l = 16'd4;
    clearObs();
    launch(s, d, l);
    observe(10, -1);
    checks++; if (wrAddrQ.size() != 4) begin failures++; $display("FAIL basic_wrcount got=%0d exp=4", wrAddrQ.size()); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= wrAddrQ.size()) begin failures++; $display("FAIL basic_write%0d missing", j); end
      else if (wrAddrQ[j] !== d + 16'(j) || wrDataQ[j] !== memWord(s + 16'(j)) || wrCycQ[j] != j + 1) begin
        failures++;
        $display("FAIL basic_write%0d got addr=%h cyc=%0d data=%h exp addr=%h cyc=%0d data=%h",
                 j, wrAddrQ[j], wrCycQ[j], wrDataQ[j], d + 16'(j), j + 1, memWord(s + 16'(j)));
      end
    end
    checks++; if (doneCycQ.size() != 1 || doneCycQ[0] != 5) begin failures++; $display("FAIL basic_done got count=%0d first=%0d exp count=1 cycle=5", doneCycQ.size(), (doneCycQ.size() > 0) ? doneCycQ[0] : -1); end
    checks++; if (busyCnt != 6) begin failures++; $display("FAIL basic_busy got=%0d exp=6", busyCnt); end
    checks++; if (holdErr != 0) begin failures++; $display("FAIL basic_addrhold got=%0d exp=0 changes", holdErr); end
  endtask

  task automatic test_zero_length();
    clearObs();
    launch(16'h1111, 16'h2222, 16'd0);
    observe(6, -1);
    checks++; if (wrAddrQ.size() != 0) begin failures++; $display("FAIL zero_wrcount got=%0d exp=0", wrAddrQ.size()); end
    checks++; if (doneCycQ.size() != 1 || doneCycQ[0] != 0) begin failures++; $display("FAIL zero_done got count=%0d first=%0d exp count=1 cycle=0", doneCycQ.size(), (doneCycQ.size() > 0) ? doneCycQ[0] : -1); end
    checks++; if (busyCnt != 1) begin failures++; $display("FAIL zero_busy got=%0d exp=1", busyCnt); end
  endtask

  task automatic test_wrap();
    logic [15:0] rdExp[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [15:0] wrExp[3] = '{16'hFFFF, 16'h0000, 16'h0001};
    clearObs();
    launch(16'hFFFE, 16'hFFFF, 16'd3);
    observe(8, -1);
    checks++; if (wrAddrQ.size() != 3) begin failures++; $display("FAIL wrap_wrcount got=%0d exp=3", wrAddrQ.size()); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rdAddrQ[j] !== rdExp[j]) begin failures++; $display("FAIL wrap_read%0d got=%h exp=%h", j, rdAddrQ[j], rdExp[j]); end
      checks++;
      if (j >= wrAddrQ.size()) begin failures++; $display("FAIL wrap_write%0d missing", j); end
      else if (wrAddrQ[j] !== wrExp[j] || wrDataQ[j] !== memWord(rdExp[j])) begin
        failures++; $display("FAIL wrap_write%0d got addr=%h data=%h exp addr=%h data=%h", j, wrAddrQ[j], wrDataQ[j], wrExp[j], memWord(rdExp[j]));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [15:0] s, d, l;
      int expDone, expBusy;
      s = 16'($urandom);
      d = 16'($urandom);
      if (it % 3 == 0) s = 16'hFFFF - 16'($urandom_range(0, 4));
      l = 16'($urandom_range(0, 10));
      expDone = (l == 0) ? 0 : int'(l) + 1;
      expBusy = (l == 0) ? 1 : int'(l) + 2;
      clearObs();
      launch(s, d, l);
      observe(int'(l) + 6, -1);
      checks++; if (wrAddrQ.size() != int'(l)) begin failures++; $display("FAIL rand%0d_wrcount got=%0d exp=%0d", it, wrAddrQ.size(), l); end
      for (int j = 0; j < int'(l) && j < wrAddrQ.size(); j++) begin
        checks++;
        if (wrAddrQ[j] !== d + 16'(j) || wrDataQ[j] !== memWord(s + 16'(j)) || wrCycQ[j] != j + 1) begin
          failures++;
          $display("FAIL rand%0d_write%0d got addr=%h cyc=%0d exp addr=%h cyc=%0d src=%h", it, j, wrAddrQ[j], wrCycQ[j], d + 16'(j), j + 1, s + 16'(j));
        end
      end
      checks++; if (doneCycQ.size() != 1 || doneCycQ[0] != expDone) begin failures++; $display("FAIL rand%0d_done got count=%0d first=%0d exp cycle=%0d", it, doneCycQ.size(), (doneCycQ.size() > 0) ? doneCycQ[0] : -1, expDone); end
      checks++; if (busyCnt != expBusy) begin failures++; $display("FAIL rand%0d_busy got=%0d exp=%0d", it, busyCnt, expBusy); end
      checks++; if (holdErr != 0) begin failures++; $display("FAIL rand%0d_addrhold got=%0d exp=0", it, holdErr); end
    end
  endtask

  task automatic test_start_held();
    clearObs();
    launch(16'h0300, 16'h0500, 16'd3);
    observe(14, -1);
    checks++; if (wrAddrQ.size() != 3) begin failures++; $display("FAIL held_wrcount got=%0d exp=3", wrAddrQ.size()); end
    checks++; if (doneCycQ.size() != 1) begin failures++; $display("FAIL held_donecount got=%0d exp=1", doneCycQ.size()); end
    clearObs();
    launch(16'h0400, 16'h0600, 16'd2);
    observe(8, -1);
    checks++; if (wrAddrQ.size() != 2) begin failures++; $display("FAIL held_second_wrcount got=%0d exp=2", wrAddrQ.size()); end
    checks++; if (wrAddrQ.size() != 2 || wrAddrQ[0] !== 16'h0600 || wrDataQ[1] !== memWord(16'h0401)) begin failures++; $display("FAIL held_second_content got first=%h exp first=0600", (wrAddrQ.size() > 0) ? wrAddrQ[0] : 16'hxxxx); end
    start = 1'b0;
  endtask

  task automatic test_restart_ignored();
    clearObs();
    altSrc = 16'h7000; altDst = 16'h7800; altLen = 16'd2;
    launch(16'h0100, 16'h0800, 16'd6);
    observe(14, 1);
    checks++; if (wrAddrQ.size() != 6) begin failures++; $display("FAIL restart_wrcount got=%0d exp=6", wrAddrQ.size()); end
    for (int j = 0; j < 6 && j < wrAddrQ.size(); j++) begin
      checks++;
      if (wrAddrQ[j] !== 16'h0800 + 16'(j) || wrDataQ[j] !== memWord(16'h0100 + 16'(j))) begin
        failures++; $display("FAIL restart_write%0d got addr=%h exp addr=%h", j, wrAddrQ[j], 16'h0800 + 16'(j));
      end
    end
    checks++; if (doneCycQ.size() != 1 || doneCycQ[0] != 7) begin failures++; $display("FAIL restart_done got count=%0d first=%0d exp count=1 cycle=7", doneCycQ.size(), (doneCycQ.size() > 0) ? doneCycQ[0] : -1); end
    start = 1'b0;
  endtask

  task automatic test_reset_abort();
    clearObs();
    launch(16'h1234, 16'h4000, 16'd8);
    observe(3, -1);
    checks++; if (wrAddrQ.size() != 2) begin failures++; $display("FAIL abort_prewrites got=%0d exp=2", wrAddrQ.size()); end
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (Dst_WriteEnable !== 1'b0) begin failures++; $display("FAIL abort_wren got=%b exp=0", Dst_WriteEnable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
    clearObs();
    observe(12, -1);
    checks++; if (wrAddrQ.size() != 0) begin failures++; $display("FAIL abort_postwrites got=%0d exp=0", wrAddrQ.size()); end
    checks++; if (doneCycQ.size() != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", doneCycQ.size()); end
    checks++; if (busyCnt != 0) begin failures++; $display("FAIL abort_idle busy cycles got=%0d exp=0", busyCnt); end
  endtask

  task automatic test_reset_start_held();
    @(negedge clock);
    reset_n = 1'b0;
    start = 1'b1; src_base = 16'h0AB0; dst_base = 16'h0C00; length = 16'd2;
    @(negedge clock);
    clearObs();
    reset_n = 1'b1;
    observe(8, -1);
    checks++; if (wrAddrQ.size() != 2) begin failures++; $display("FAIL rststart_wrcount got=%0d exp=2", wrAddrQ.size()); end
    checks++; if (wrAddrQ.size() != 2 || wrAddrQ[1] !== 16'h0C01 || wrDataQ[0] !== memWord(16'h0AB0)) begin failures++; $display("FAIL rststart_content got second=%h exp=0c01", (wrAddrQ.size() > 1) ? wrAddrQ[1] : 16'hxxxx); end
    checks++; if (doneCycQ.size() != 1 || doneCycQ[0] != 3) begin failures++; $display("FAIL rststart_done got count=%0d first=%0d exp cycle=3", doneCycQ.size(), (doneCycQ.size() > 0) ? doneCycQ[0] : -1); end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_random();
    test_start_held();
    test_restart_ignored();
    test_reset_abort();
    test_reset_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
